registro_univ: RTL and testbench
================================

# registro_univ

Parametrised universal shift register and successor to the 2-bit-mode conditional register. It adds multi-bit serial lanes, arithmetic shift, clear and invert modes, and a self-timed repeat sequencer with BUSY/DONE handshake. Switching activity is exposed as a saturating toggle counter port rather than through hierarchical references. It sits in the register/datapath layer and is driven by a controller that issues one command and waits for DONE.

## Interface
- WIDTH, 8: register width; WIDTH ≥ 2.
- LANE, 1: bits shifted per step and serial port width; 1 ≤ LANE < WIDTH.
- REP_W, 4: width of the repeat field.
- CNT_W, 16: width of the toggle counter.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ENB  in  1  global enable; 0 freezes all state, including the sequencer and counter.
- START  in  1  command strobe.
- MODO  in  3  command mode; sampled only on acceptance.
- DIR  in  1  direction: 0 = toward MSB (left), 1 = toward LSB (right); sampled only on acceptance.
- REP  in  REP_W  extra repetitions; a command performs REP+1 steps.
- D  in  WIDTH  parallel load data; sampled live on every LOAD step.
- S_IN  in  LANE  serial input; sampled live on every PUSH step.
- Q  out  WIDTH  register contents.
- S_OUT  out  LANE  serial output.
- BUSY  out  1  high while the remaining steps of a command are pending.
- DONE  out  1  single-cycle pulse marking command completion.
- PWR_CNT  out  CNT_W  cumulative count of Q bit toggles.

## Operation
- States are IDLE and RUN, with an internal down-counter `rem` of width REP_W.
- **Acceptance:** a command is accepted on a rising edge with START=1, ENB=1 and state IDLE.
  - MODO and DIR are latched.
  - Step 1 executes on that same edge.
  - If REP=0: stay in IDLE and set DONE=1.
  - Otherwise: rem ← REP, go to RUN, BUSY=1.
- **RUN:** each edge with ENB=1 executes one step and decrements rem.
  - When rem==1 at the edge: go to IDLE, BUSY←0, DONE←1.
  - START is ignored throughout RUN.
- **IDLE without acceptance:** Q and S_OUT hold; DONE←0.
- **Step definitions.** "out-bits" means Q[WIDTH-1 -: LANE] for DIR=0 and Q[LANE-1:0] for DIR=1.
  - 000 PUSH:
    - DIR=0: Q←{Q[WIDTH-LANE-1:0], S_IN}.
    - DIR=1: Q←{S_IN, Q[WIDTH-1:LANE]}.
    - S_OUT←out-bits.
  - 001 CYCLE: rotate by LANE in DIR; S_OUT←0.
  - 010 LOAD: Q←D; S_OUT←0.
  - 011 ARITH:
    - DIR=0: shift left by LANE with zero fill.
    - DIR=1: shift right by LANE replicating Q[WIDTH-1].
    - S_OUT←out-bits.
  - 100 CLEAR: Q←0; S_OUT←0.
  - 101 INVERT: Q←~Q; S_OUT←0.
  - 110/111 reserved: Q holds; S_OUT←0. Each still counts as a step.
- **PWR_CNT:** on every enabled edge, add popcount(Q_old ^ Q_new).
  - Saturates at 2^CNT_W−1 and never wraps.
  - Edges with ENB=0 or no Q change add 0.

## Timing
- **Reset values:** Q=0, S_OUT=0, BUSY=0, DONE=0, PWR_CNT=0, rem=0, state IDLE.
- **Latency:** Q reflects step k at the k-th enabled edge after acceptance, counting the acceptance edge as edge 1.
  - BUSY rises at the acceptance edge (when REP>0) and falls at the final step edge.
  - DONE is high during the cycle after the final step edge.
- **ENB=0 mid-command:** the sequence stalls with no step, rem unchanged, BUSY held high. A DONE already high stays high until the next enabled edge.
- **Back-to-back commands:** START may be accepted in the DONE cycle. DONE then falls and the new step 1 executes on that edge; no idle cycle is required.
- **Mid-command reset:** RST asserted during RUN aborts immediately. No DONE pulse is produced and all outputs take their reset values asynchronously.
- **Sampling:** S_IN and D are sampled per step, not latched, so the driver may stream new values each cycle.

## Test plan
- WIDTH=8, LANE=1, DIR=0: Q=0x81, PUSH, REP=2, S_IN=1,0,1 on successive edges.
  - Q after each edge: 0x03, 0x06, 0x0D.
  - S_OUT after each edge: 1, 0, 0.
  - BUSY high for 2 cycles; DONE pulses once after the 3rd edge.
- LANE=2, CYCLE, DIR=1, REP=0, Q=0xB4 → Q=0x2D, S_OUT=0, DONE the next cycle, BUSY never high.
- LANE=1, ARITH, DIR=1, REP=3, Q=0x90 → Q=0xF9, final S_OUT=0.
- LOAD D=0xFF from 0x00, then INVERT → PWR_CNT=8, then 16.
  - With CNT_W=4 the same sequence saturates at 15.
- ENB=0 for 2 cycles during a REP=3 PUSH → Q, rem and PWR_CNT frozen; BUSY stays 1; completion is delayed by exactly 2 cycles.
- RST pulse at step 2 of a REP=5 command → all outputs 0 immediately; no DONE.
  - A fresh START after reset executes normally.

Source files
------------

// File: rtl/registro_univ.sv
// Universal shift register: push, rotate, load, arithmetic shift, clear and invert steps,
// a REP+1 step sequencer with BUSY/DONE handshake, and a saturating Q toggle counter.
module registro_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANE  = 1,
  parameter int unsigned REP_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             START,
  input  logic [2:0]       MODO,
  input  logic             DIR,
  input  logic [REP_W-1:0] REP,
  input  logic [WIDTH-1:0] D,
  input  logic [LANE-1:0]  S_IN,
  output logic [WIDTH-1:0] Q,
  output logic [LANE-1:0]  S_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] PWR_CNT
);

  localparam int unsigned PopW = $clog2(WIDTH + 1);
  localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  localparam logic [2:0] ModePush   = 3'b000;
  localparam logic [2:0] ModeCycle  = 3'b001;
  localparam logic [2:0] ModeLoad   = 3'b010;
  localparam logic [2:0] ModeArith  = 3'b011;
  localparam logic [2:0] ModeClear  = 3'b100;
  localparam logic [2:0] ModeInvert = 3'b101;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [REP_W-1:0] rem_q;
  logic [2:0]       mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] q_q, q_d, step_q;
  logic [LANE-1:0]  sout_q, sout_d, step_so, out_bits;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] pwr_q, pwr_d;
  logic             accept, do_step, step_dir;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] diff;
  logic [PopW-1:0]  toggles;
  logic [SumW-1:0]  sum;

  // The acceptance edge executes step 1 with the live MODO/DIR, later steps use the latched copy.
  always_comb begin
    accept    = ENB && START && (state_q == StIdle);
    do_step   = ENB && (accept || (state_q == StRun));
    step_mode = accept ? MODO : mode_q;
    step_dir  = accept ? DIR : dir_q;
    out_bits  = step_dir ? q_q[LANE-1:0] : q_q[WIDTH-1 -: LANE];
    step_q    = q_q;
    step_so   = '0;
    case (step_mode)
      ModePush: begin
        step_q  = step_dir ? {S_IN, q_q[WIDTH-1:LANE]} : {q_q[WIDTH-LANE-1:0], S_IN};
        step_so = out_bits;
      end
      ModeCycle: begin
        step_q = step_dir ? {q_q[LANE-1:0], q_q[WIDTH-1:LANE]}
                          : {q_q[WIDTH-LANE-1:0], q_q[WIDTH-1 -: LANE]};
      end
      ModeLoad:  step_q = D;
      ModeArith: begin
        step_q  = step_dir ? {{LANE{q_q[WIDTH-1]}}, q_q[WIDTH-1:LANE]}
                           : {q_q[WIDTH-LANE-1:0], {LANE{1'b0}}};
        step_so = out_bits;
      end
      ModeClear:  step_q = '0;
      ModeInvert: step_q = ~q_q;
      default:    step_q = q_q;
    endcase
    q_d    = do_step ? step_q : q_q;
    sout_d = do_step ? step_so : sout_q;
  end

  always_comb begin
    diff    = q_q ^ q_d;
    toggles = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      toggles = toggles + PopW'(diff[i]);
    end
    sum   = SumW'(pwr_q) + SumW'(toggles);
    pwr_d = (sum > SumW'(CntMax)) ? CntMax : sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      rem_q   <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      sout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pwr_q   <= '0;
    end else if (ENB) begin
      q_q    <= q_d;
      sout_q <= sout_d;
      pwr_q  <= pwr_d;
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (START) begin
            mode_q <= MODO;
            dir_q  <= DIR;
            if (REP == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q   <= REP;
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          rem_q  <= rem_q - 1'b1;
          done_q <= 1'b0;
          if (rem_q == REP_W'(1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Q       = q_q;
  assign S_OUT   = sout_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PWR_CNT = pwr_q;

endmodule

// File: tb/tb_registro_univ.sv
// Bench for registro_univ: two instances (LANE=1/CNT_W=16 and LANE=2/CNT_W=4) against a
// step-count reference model, with directed scenarios followed by random commands.
module tb_registro_univ;

  logic       clk = 1'b0;
  logic       rst, enb, start, dir;
  logic [2:0] modo;
  logic [3:0] rep;
  logic [7:0] d;
  logic       s_in_a;
  logic [1:0] s_in_b;

  logic [7:0]  q_a, q_b;
  logic        so_a, busy_a, done_a, busy_b, done_b;
  logic [1:0]  so_b;
  logic [15:0] pwr_a;
  logic [3:0]  pwr_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: steps still pending after the current one
  int       m_pend[2];
  int       m_pwr[2];
  bit [7:0] m_q[2];
  bit [7:0] m_so[2];
  bit [2:0] m_mode[2];
  bit       m_dir[2];
  bit       m_done[2];

  always #5 clk = ~clk;

  registro_univ #(.WIDTH(8), .LANE(1), .REP_W(4), .CNT_W(16)) u_a (
    .CLK(clk), .RST(rst), .ENB(enb), .START(start), .MODO(modo), .DIR(dir), .REP(rep),
    .D(d), .S_IN(s_in_a), .Q(q_a), .S_OUT(so_a), .BUSY(busy_a), .DONE(done_a),
    .PWR_CNT(pwr_a)
  );

  registro_univ #(.WIDTH(8), .LANE(2), .REP_W(4), .CNT_W(4)) u_b (
    .CLK(clk), .RST(rst), .ENB(enb), .START(start), .MODO(modo), .DIR(dir), .REP(rep),
    .D(d), .S_IN(s_in_b), .Q(q_b), .S_OUT(so_b), .BUSY(busy_b), .DONE(done_b),
    .PWR_CNT(pwr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit [2:0] mode, input bit dr);
    int lane, mask, qi, qn, outb, sin, cap, tog;
    bit signed [7:0] sq;
    lane = i + 1;
    mask = (1 << lane) - 1;
    qi   = int'(m_q[i]);
    sin  = (i == 0) ? int'(s_in_a) : int'(s_in_b);
    outb = dr ? (qi & mask) : (qi >> (8 - lane));
    sq   = m_q[i];
    qn   = qi;
    m_so[i] = 8'h00;
    case (mode)
      3'd0: begin
        qn = dr ? ((qi >> lane) | (sin << (8 - lane))) : ((qi << lane) | sin);
        m_so[i] = 8'(outb);
      end
      3'd1: qn = dr ? ((qi >> lane) | (qi << (8 - lane))) : ((qi << lane) | (qi >> (8 - lane)));
      3'd2: qn = int'(d);
      3'd3: begin
        qn = dr ? int'(8'(sq >>> lane)) : (qi << lane);
        m_so[i] = 8'(outb);
      end
      3'd4: qn = 0;
      3'd5: qn = ~qi;
      default: qn = qi;
    endcase
    qn  = qn & 8'hFF;
    tog = $countones(qi ^ qn);
    cap = (i == 0) ? 65535 : 15;
    m_pwr[i] = (m_pwr[i] + tog > cap) ? cap : m_pwr[i] + tog;
    m_q[i]   = 8'(qn);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (enb) begin
        if (m_pend[i] > 0) begin
          model_step(i, m_mode[i], m_dir[i]);
          m_pend[i]--;
          m_done[i] = (m_pend[i] == 0);
        end else if (start) begin
          m_mode[i] = modo;
          m_dir[i]  = dir;
          model_step(i, modo, dir);
          m_pend[i] = int'(rep);
          m_done[i] = (rep == 4'd0);
        end else begin
          m_done[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("q_a", 32'(q_a), 32'(m_q[0]));
    check("so_a", 32'(so_a), 32'(m_so[0]));
    check("busy_a", 32'(busy_a), 32'(m_pend[0] != 0));
    check("done_a", 32'(done_a), 32'(m_done[0]));
    check("pwr_a", 32'(pwr_a), 32'(m_pwr[0]));
    check("q_b", 32'(q_b), 32'(m_q[1]));
    check("so_b", 32'(so_b), 32'(m_so[1]));
    check("busy_b", 32'(busy_b), 32'(m_pend[1] != 0));
    check("done_b", 32'(done_b), 32'(m_done[1]));
    check("pwr_b", 32'(pwr_b), 32'(m_pwr[1]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_so[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_pwr[i] = 0;
      m_mode[i] = 0; m_dir[i] = 0;
    end
  endtask

  // Reset is raised between edges so its effect must be asynchronous
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cmd(input bit [2:0] m, input bit dr, input bit [3:0] r, input bit [7:0] dd);
    start = 1'b1; modo = m; dir = dr; rep = r; d = dd;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; start = 1'b0; modo = 3'd0; dir = 1'b0; rep = 4'd0;
    d = 8'h00; s_in_a = 1'b0; s_in_b = 2'b00;
    model_reset();
    #12;
    compare_all();
    rst = 1'b0;
    @(negedge clk);

    // Load all-ones then invert: 8 then 16 toggles, narrow counter saturates at 15
    cmd(3'd2, 1'b0, 4'd0, 8'hFF);
    check("pwr_load_a", 32'(pwr_a), 32'd8);
    check("pwr_load_b", 32'(pwr_b), 32'd8);
    cmd(3'd5, 1'b0, 4'd0, 8'h00);
    check("pwr_inv_a", 32'(pwr_a), 32'd16);
    check("pwr_inv_b", 32'(pwr_b), 32'd15);
    tick();

    // Serial push left from 0x81 with S_IN 1,0,1
    cmd(3'd2, 1'b0, 4'd0, 8'h81);
    tick();
    s_in_a = 1'b1;
    cmd(3'd0, 1'b0, 4'd2, 8'h00);
    check("push1_q", 32'(q_a), 32'h03);
    check("push1_so", 32'(so_a), 32'd1);
    check("push1_busy", 32'(busy_a), 32'd1);
    s_in_a = 1'b0;
    tick();
    check("push2_q", 32'(q_a), 32'h06);
    check("push2_so", 32'(so_a), 32'd0);
    s_in_a = 1'b1;
    tick();
    check("push3_q", 32'(q_a), 32'h0D);
    check("push3_done", 32'(done_a), 32'd1);
    check("push3_busy", 32'(busy_a), 32'd0);
    tick();
    check("push_done_fall", 32'(done_a), 32'd0);

    // Two-bit rotate right of 0xB4 in a single step
    cmd(3'd2, 1'b0, 4'd0, 8'hB4);
    cmd(3'd1, 1'b1, 4'd0, 8'h00);
    check("cyc_q_b", 32'(q_b), 32'h2D);
    check("cyc_done_b", 32'(done_b), 32'd1);
    check("cyc_busy_b", 32'(busy_b), 32'd0);

    // Back-to-back: load 0x90 in the DONE cycle, then four arithmetic right shifts
    cmd(3'd2, 1'b0, 4'd0, 8'h90);
    cmd(3'd3, 1'b1, 4'd3, 8'h00);
    tick(); tick(); tick();
    check("arith_q_a", 32'(q_a), 32'hF9);
    check("arith_so_a", 32'(so_a), 32'd0);
    check("arith_done_a", 32'(done_a), 32'd1);

    // Stall two cycles inside a four-step push
    cmd(3'd0, 1'b0, 4'd3, 8'h00);
    tick();
    enb = 1'b0;
    tick(); tick();
    check("stall_busy", 32'(busy_a), 32'd1);
    enb = 1'b1;
    tick();
    check("stall_not_done", 32'(done_a), 32'd0);
    tick();
    check("stall_done", 32'(done_a), 32'd1);

    // Reset during step 2 of a six-step command, then a fresh command
    tick();
    cmd(3'd5, 1'b0, 4'd5, 8'h00);
    tick();
    do_reset();
    check("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    cmd(3'd2, 1'b0, 4'd0, 8'h5A);
    check("post_rst_q", 32'(q_a), 32'h5A);
    check("post_rst_done", 32'(done_a), 32'd1);

    // Random commands, stalls and occasional resets
    for (int n = 0; n < 600; n++) begin
      enb    = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 1) == 1);
      modo   = 3'($urandom_range(0, 7));
      dir    = 1'($urandom_range(0, 1));
      rep    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      d      = 8'($urandom);
      s_in_a = 1'($urandom);
      s_in_b = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
